// File: rtl/io_port_bridge.sv
// io_port_bridge: decodes the processor's sequence-toggled write_out word into TX pushes / RX pops
// and serves read_in from the RX FIFO. Define IO_BRIDGE_OVF_EN to build the sticky tx_ovf flag.
module io_port_bridge #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] proc_write_out,
    output logic [15:0] proc_read_in,
    output logic [13:0] host_tx_data,
    output logic        host_tx_valid,
    input  logic        host_tx_ready,
    input  logic [13:0] host_rx_data,
    input  logic        host_rx_valid,
    output logic        host_rx_ready,
    output logic        tx_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    logic [15:0] wo_q;
    logic        seq_q, ev, tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [13:0] tx_mem [DEPTH];
    logic [13:0] rx_mem [DEPTH];

    assign ev       = wo_q[14] != seq_q;
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = tx_wp == {~tx_rp[AW], tx_rp[AW-1:0]};
    assign rx_empty = rx_wp == rx_rp;
    assign rx_full  = rx_wp == {~rx_rp[AW], rx_rp[AW-1:0]};
    // Fullness is taken before the host pop, so a push into a full FIFO is dropped even if a slot frees now.
    assign tx_push  = ev && !wo_q[15] && !tx_full;
    assign tx_pop   = !tx_empty && host_tx_ready;
    assign rx_push  = host_rx_valid && !rx_full;
    assign rx_pop   = ev && wo_q[15] && wo_q[0] && !rx_empty;

    assign host_tx_valid = !tx_empty;
    assign host_tx_data  = tx_empty ? 14'h0 : tx_mem[tx_rp[AW-1:0]];
    assign host_rx_ready = !rx_full;
    assign proc_read_in  = {!rx_empty, tx_full, rx_empty ? 14'h0 : rx_mem[rx_rp[AW-1:0]]};

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wo_q  <= '0;
            seq_q <= 1'b0;
        end else begin
            wo_q  <= proc_write_out;
            seq_q <= wo_q[14];
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_mem <= '{default: '0};
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp[AW-1:0]] <= wo_q[13:0];
                tx_wp <= tx_wp + PTR_ONE;
            end
            if (tx_pop) tx_rp <= tx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_mem <= '{default: '0};
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp[AW-1:0]] <= host_rx_data;
                rx_wp <= rx_wp + PTR_ONE;
            end
            if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
        end
    end

`ifdef IO_BRIDGE_OVF_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) tx_ovf <= 1'b0;
        else if (ev && !wo_q[15] && tx_full) tx_ovf <= 1'b1;
    end
`else
    assign tx_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed scenarios plus random traffic against a queue-based model of the bridge.
module tb_io_port_bridge;
    localparam int DEPTH = 4;
    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pw = '0;
    logic [15:0] proc_read_in;
    logic [13:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready = 1'b0;
    logic [13:0] host_rx_data = '0;
    logic        host_rx_valid = 1'b0;
    logic        host_rx_ready;
    logic        tx_ovf;
    int          errs = 0;
    int          checks = 0;
    logic        seq_sw = 1'b0;
    logic [13:0] txq[$];
    logic [13:0] rxq[$];
    logic [15:0] h1 = '0, h2 = '0;
    logic        m_ovf = 1'b0;

    io_port_bridge #(.DEPTH(DEPTH)) dut (
        .clock(clock), .rst(rst), .proc_write_out(pw), .proc_read_in(proc_read_in),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .tx_ovf(tx_ovf)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] exp_read_in();
        return {rxq.size() != 0, txq.size() == DEPTH, rxq.size() != 0 ? rxq[0] : 14'h0};
    endfunction

    function automatic logic exp_ovf();
`ifdef IO_BRIDGE_OVF_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wr(input logic cmd, input logic [13:0] payload);
        seq_sw = ~seq_sw;
        pw = {cmd, seq_sw, payload};
    endtask

    // One clock: the model sees what was on the inputs at the edge, with the write word two edges old.
    task automatic step();
        logic [15:0] w = pw;
        logic rdy = host_tx_ready;
        logic rv = host_rx_valid;
        logic [13:0] rd = host_rx_data;
        logic ev, tfull, rfull, rnon;
        @(posedge clock);
        ev = h1[14] != h2[14];
        tfull = txq.size() == DEPTH;
        rfull = rxq.size() == DEPTH;
        rnon = rxq.size() != 0;
        if (txq.size() != 0 && rdy) void'(txq.pop_front());
        if (ev && !h1[15]) begin
            if (tfull) m_ovf = 1'b1;
            else txq.push_back(h1[13:0]);
        end
        if (ev && h1[15] && h1[0] && rnon) void'(rxq.pop_front());
        if (rv && !rfull) rxq.push_back(rd);
        h2 = h1;
        h1 = w;
        #1;
    endtask

    task automatic assert_reset();
        #1 rst = 1'b0;
        pw = '0; seq_sw = 1'b0; host_tx_ready = 1'b0; host_rx_valid = 1'b0; host_rx_data = '0;
        txq.delete(); rxq.delete(); h1 = '0; h2 = '0; m_ovf = 1'b0;
        #1;
    endtask

    task automatic release_reset(input int n);
        repeat (n) @(posedge clock);
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++; if (proc_read_in !== 16'h0000) begin errs++; $display("FAIL reset_read_in got %h want 0000", proc_read_in); end
        release_reset(3);
        checks++; if (proc_read_in !== 16'h0000) begin errs++; $display("FAIL reset_read_in_post got %h want 0000", proc_read_in); end
        checks++; if (host_tx_valid !== 1'b0) begin errs++; $display("FAIL reset_tx_valid got %b want 0", host_tx_valid); end
        checks++; if (host_tx_data !== 14'h0) begin errs++; $display("FAIL reset_tx_data got %h want 0", host_tx_data); end
        checks++; if (host_rx_ready !== 1'b1) begin errs++; $display("FAIL reset_rx_ready got %b want 1", host_rx_ready); end
        checks++; if (tx_ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", tx_ovf); end
    endtask

    task automatic test_repeat_write();
        assert_reset();
        release_reset(2);
        wr(1'b0, 14'h0123);
        step();
        checks++; if (host_tx_valid !== 1'b0) begin errs++; $display("FAIL rep_valid_early got %b want 0", host_tx_valid); end
        wr(1'b0, 14'h0123);
        step();
        checks++; if (host_tx_valid !== 1'b1 || host_tx_data !== 14'h0123) begin errs++; $display("FAIL rep_first got v=%b d=%h want v=1 d=0123", host_tx_valid, host_tx_data); end
        step();
        host_tx_ready = 1'b1;
        step();
        checks++; if (host_tx_valid !== 1'b1 || host_tx_data !== 14'h0123) begin errs++; $display("FAIL rep_second got v=%b d=%h want v=1 d=0123", host_tx_valid, host_tx_data); end
        step();
        checks++; if (host_tx_valid !== 1'b0) begin errs++; $display("FAIL rep_drained got %b want 0", host_tx_valid); end
        host_tx_ready = 1'b0;
    endtask

    task automatic test_rx_path();
        assert_reset();
        release_reset(2);
        host_rx_valid = 1'b1; host_rx_data = 14'h0011;
        step();
        host_rx_data = 14'h0022;
        step();
        host_rx_valid = 1'b0;
        checks++; if (proc_read_in !== 16'h8011) begin errs++; $display("FAIL rx_head got %h want 8011", proc_read_in); end
        wr(1'b1, 14'h0001);
        step();
        checks++; if (proc_read_in !== 16'h8011) begin errs++; $display("FAIL rx_pop_early got %h want 8011", proc_read_in); end
        step();
        checks++; if (proc_read_in !== 16'h8022) begin errs++; $display("FAIL rx_pop1 got %h want 8022", proc_read_in); end
        wr(1'b1, 14'h0001);
        step(); step();
        checks++; if (proc_read_in !== 16'h0000) begin errs++; $display("FAIL rx_pop2 got %h want 0000", proc_read_in); end
        wr(1'b1, 14'h0001);
        step(); step();
        checks++; if (proc_read_in !== 16'h0000) begin errs++; $display("FAIL rx_pop_empty got %h want 0000", proc_read_in); end
    endtask

    task automatic test_tx_full();
        logic [13:0] w[5];
        assert_reset();
        release_reset(2);
        for (int i = 0; i < 5; i++) w[i] = 14'($urandom);
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, w[i]);
            step();
        end
        step();
        checks++; if (proc_read_in[14] !== 1'b1) begin errs++; $display("FAIL txfull_flag got %b want 1", proc_read_in[14]); end
        checks++; if (tx_ovf !== 1'b0) begin errs++; $display("FAIL txfull_ovf_early got %b want 0", tx_ovf); end
        wr(1'b0, w[4]);
        step(); step();
        checks++; if (tx_ovf !== exp_ovf()) begin errs++; $display("FAIL txfull_ovf got %b want %b", tx_ovf, exp_ovf()); end
        host_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (host_tx_valid !== 1'b1 || host_tx_data !== w[i]) begin errs++; $display("FAIL tx_drain%0d got v=%b d=%h want v=1 d=%h", i, host_tx_valid, host_tx_data, w[i]); end
            step();
        end
        checks++; if (host_tx_valid !== 1'b0) begin errs++; $display("FAIL tx_drain_end got %b want 0", host_tx_valid); end
        checks++; if (tx_ovf !== exp_ovf()) begin errs++; $display("FAIL txfull_ovf_sticky got %b want %b", tx_ovf, exp_ovf()); end
        host_tx_ready = 1'b0;
    endtask

    task automatic test_rx_full_wrap();
        logic [13:0] w[14];
        assert_reset();
        release_reset(2);
        for (int i = 0; i < 14; i++) w[i] = 14'($urandom);
        host_rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host_rx_data = w[i];
            step();
            if (i == 2) begin
                checks++; if (host_rx_ready !== 1'b1) begin errs++; $display("FAIL rx_ready_3 got %b want 1", host_rx_ready); end
            end
            if (i == 3) begin
                checks++; if (host_rx_ready !== 1'b0) begin errs++; $display("FAIL rx_ready_4 got %b want 0", host_rx_ready); end
            end
        end
        host_rx_valid = 1'b0;
        checks++; if (proc_read_in !== {2'b10, w[0]}) begin errs++; $display("FAIL rx_full_head got %h want %h", proc_read_in, {2'b10, w[0]}); end
        for (int k = 0; k < 10; k++) begin
            wr(1'b1, 14'h0001);
            step(); step();
            host_rx_valid = 1'b1; host_rx_data = w[k + 4];
            step();
            host_rx_valid = 1'b0;
            checks++; if (proc_read_in !== {2'b10, w[k + 1]}) begin errs++; $display("FAIL rx_wrap%0d got %h want %h", k, proc_read_in, {2'b10, w[k + 1]}); end
        end
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset(2);
        host_rx_valid = 1'b1; host_rx_data = 14'h0101;
        wr(1'b0, 14'h0A0A);
        step();
        host_rx_data = 14'h0202;
        wr(1'b0, 14'h0B0B);
        step();
        host_rx_valid = 1'b0;
        step();
        checks++; if (proc_read_in !== exp_read_in() || txq.size() != 2) begin errs++; $display("FAIL mid_prefill got %h want %h", proc_read_in, exp_read_in()); end
        assert_reset();
        checks++; if (proc_read_in !== 16'h0000 || host_tx_valid !== 1'b0 || host_tx_data !== 14'h0 || host_rx_ready !== 1'b1 || tx_ovf !== 1'b0)
            begin errs++; $display("FAIL mid_reset got ri=%h tv=%b td=%h rr=%b ovf=%b want 0000 0 0 1 0", proc_read_in, host_tx_valid, host_tx_data, host_rx_ready, tx_ovf); end
        release_reset(2);
        wr(1'b0, 14'h02AB);
        step(); step();
        checks++; if (host_tx_valid !== 1'b1 || host_tx_data !== 14'h02AB || proc_read_in !== 16'h0000)
            begin errs++; $display("FAIL mid_after got v=%b d=%h ri=%h want 1 02ab 0000", host_tx_valid, host_tx_data, proc_read_in); end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset(2);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) wr($urandom_range(0, 2) == 0, 14'($urandom));
            else pw = {1'($urandom), pw[14], 14'($urandom)};
            host_tx_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            host_rx_valid = $urandom_range(0, 1) == 0;
            host_rx_data = 14'($urandom);
            step();
            checks++; if (proc_read_in !== exp_read_in()) begin errs++; $display("FAIL rnd%0d_read_in got %h want %h", n, proc_read_in, exp_read_in()); end
            checks++; if (host_tx_valid !== (txq.size() != 0) || (txq.size() != 0 && host_tx_data !== txq[0]))
                begin errs++; $display("FAIL rnd%0d_tx got v=%b d=%h want v=%b", n, host_tx_valid, host_tx_data, txq.size() != 0); end
            checks++; if (host_rx_ready !== (rxq.size() != DEPTH)) begin errs++; $display("FAIL rnd%0d_rx_ready got %b", n, host_rx_ready); end
            checks++; if (tx_ovf !== exp_ovf()) begin errs++; $display("FAIL rnd%0d_ovf got %b want %b", n, tx_ovf, exp_ovf()); end
        end
    endtask

    initial begin
        test_reset();
        test_repeat_write();
        test_rx_path();
        test_tx_full();
        test_rx_full_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

Host-side end of the processor's memory-mapped I/O word pair. Drives the processor's `read_in` word from an RX FIFO filled by an external host. Decodes the processor's `write_out` word, which carries a sequence-toggle protocol, into TX FIFO pushes and RX pop commands. Sits at the top level between `bingle_bicle` (`read_in`/`write_out`) and the host/testbench streams.

## Interface
- `DEPTH`, 4: entries per FIFO. Power of two, 2..16.
- `clock` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `proc_write_out` input 16: processor `write_out`. Encoding is `{cmd, seq, payload[13:0]}`.
- `proc_read_in` output 16: processor `read_in`. Encoding is `{rx_valid, tx_full, rx_head[13:0]}`.
- `host_tx_data` output 14: head of the TX FIFO.
- `host_tx_valid` output 1: TX FIFO non-empty.
- `host_tx_ready` input 1: host accepts `host_tx_data`.
- `host_rx_data` input 14: word from host.
- `host_rx_valid` input 1: host offers `host_rx_data`.
- `host_rx_ready` output 1: RX FIFO not full.
- `tx_ovf` output 1: sticky TX-overflow flag.

## Operation
- Input register `wo_q` captures `proc_write_out` every clock. `seq_q` captures `wo_q[14]` every clock.
- An event is recognized in any cycle where `wo_q[14] != seq_q`. Software toggles `seq` on every write, so identical consecutive payloads are distinct events.
- Event with `wo_q[15]=0` (data): push `wo_q[13:0]` into the TX FIFO.
- Event with `wo_q[15]=1` (command): if `wo_q[0]=1`, pop the RX FIFO. Other command bits are reserved and ignored.
- An event with `wo_q[15]=1` and `wo_q[0]=0` is a no-op.
- Data push while the TX FIFO is full: the word is dropped and `tx_ovf` is set. This holds even if the host pops in the same cycle.
- RX pop while the RX FIFO is empty: ignored.
- TX FIFO is popped when `host_tx_valid && host_tx_ready`.
- RX FIFO is pushed when `host_rx_valid && host_rx_ready`. `host_rx_ready = !rx_full`.
- `proc_read_in[15]` = RX FIFO non-empty.
- `proc_read_in[14]` = TX FIFO full.
- `proc_read_in[13:0]` = RX head word, or 0 when the RX FIFO is empty.
- `proc_read_in` is combinational from FIFO state flops only. It never depends on `proc_write_out` combinationally.
- Each FIFO is circular storage with read and write pointers of `log2(DEPTH)+1` bits. The extra MSB distinguishes full from empty. Pointers wrap modulo `2*DEPTH`.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect, and occupancy is unchanged.
- Simultaneous push and pop on an empty RX FIFO: the pop is ignored and the push takes effect.

## Timing
- Reset (`rst`=0, asynchronous) clears the following: `wo_q`=0, `seq_q`=0, all pointers, storage contents, and `tx_ovf`=0.
- Output values during reset:
  - `proc_read_in`=16'h0000
  - `host_tx_valid`=0
  - `host_tx_data`=0
  - `host_rx_ready`=1
  - `tx_ovf`=0
- Reset asserted mid-operation discards all FIFO contents immediately. No partial push or pop completes.
- Write-path latency: a `proc_write_out` change at edge N is captured into `wo_q` at edge N+1. The push or pop commits at edge N+2.
  - TX: `host_tx_valid` rises after edge N+2 when the FIFO was empty.
  - RX pop: `proc_read_in` shows the next head after edge N+2.
- Host RX latency: a word accepted at edge M is visible on `proc_read_in` after edge M.
- Host TX handshake: `host_tx_data` stays stable while `host_tx_valid && !host_tx_ready`.
- Throughput: one event per clock and one host transfer per direction per clock.

## Configuration
- `IO_BRIDGE_OVF_EN` defined: `tx_ovf` is a sticky flop. It is set on a dropped TX push and cleared only by reset.
- `IO_BRIDGE_OVF_EN` undefined: `tx_ovf` is tied to 0 and no overflow logic is built. Dropped pushes are still dropped silently.

## Test plan
- Reset: hold `rst`=0 for 3 clocks -> `proc_read_in`=16'h0000, `host_tx_valid`=0, `host_rx_ready`=1, `tx_ovf`=0.
- Repeated data write: drive `proc_write_out`=16'h4123, then 16'h0123 with `host_tx_ready`=0.
  - Required: TX FIFO holds two entries, both 14'h0123.
  - Required: `host_tx_valid` rises 2 clocks after the first change.
- RX path, DEPTH=4:
  - Host pushes 14'h0011, 14'h0022 -> `proc_read_in`=16'h8011.
  - Write 16'hC001 (pop) -> `proc_read_in`=16'h8022 after 2 clocks.
  - Write 16'h8001 (pop) -> `proc_read_in`=16'h0000.
  - A third pop -> no change.
- TX full with overflow, DEPTH=4, `host_tx_ready`=0:
  - 4 data events -> `proc_read_in[14]`=1.
  - 5th event -> word dropped; `tx_ovf`=1 when the macro is defined, 0 otherwise.
  - Releasing `host_tx_ready` then drains exactly the 4 words in order.
- RX full and wrap:
  - Host offers 6 words continuously -> `host_rx_ready` falls after 4 are accepted.
  - Interleave pops and pushes for 10 words -> words read back in order across pointer wrap.
- Reset mid-stream: assert `rst` between edges with 2 entries in each FIFO -> outputs go to reset values immediately. After release, the first data event is pushed correctly with `seq_q`=0.
